mips_bus_stall_bridge: RTL and testbench
========================================

# mips_bus_stall_bridge

Avalon-style bus bridge inserted between the `mips_cpu_bus` master port and the 32x4096 RAM slave. Latches each CPU request, stalls it for a fixed or pseudo-random number of cycles, forwards it to the RAM, captures read data and returns it. Used by the bus testbenches to prove the CPU honours `waitrequest` under variable latency. It also gathers stall statistics and flags master protocol violations.

## Interface
- `WAIT_BITS`, default 2: width of the random stall count, giving 0..2^WAIT_BITS-1 inserted cycles.
- `RANDOM`, default 1: 1 selects the LFSR stall count; 0 selects the fixed `FIXED_WAIT`.
- `FIXED_WAIT`, default 1: stall cycles per transaction when `RANDOM`=0. Range 0..2^WAIT_BITS-1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A seed of 0 is replaced by 16'h0001.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. All state clears while low.
- `s_address`, `s_write`, `s_read`, `s_writedata`[32], `s_byteenable`[4] in: CPU-side request.
- `s_waitrequest` out 1: held high until the transfer completes.
- `s_readdata` out 32: read data, valid in the cycle `s_waitrequest`=0.
- `m_address`, `m_write`, `m_read`, `m_writedata`[32], `m_byteenable`[4] out: RAM-side request. All are registered.
- `m_waitrequest` in 1 and `m_readdata` in 32: RAM-side response.
- `stall_count` out 32: saturating count of cycles with (`s_read`|`s_write`) && `s_waitrequest`.
- `protocol_error` out 1: sticky error flag, cleared only by reset.

## Operation
- FSM states: IDLE, STALL, FWD, RESP. The reset state is IDLE.
- `s_waitrequest` = (state != RESP).
- **IDLE**, `s_read` XOR `s_write` sampled high:
  - latch address, writedata, byteenable and direction;
  - load the wait count (LFSR low `WAIT_BITS` bits, or `FIXED_WAIT`);
  - step the LFSR once;
  - go to STALL if the count > 0, else FWD.
- **IDLE**, `s_read` && `s_write` both high: set `protocol_error`, load `s_readdata` with 0, go to RESP. No RAM access occurs.
- **STALL**: decrement the count each cycle. Go to FWD on the edge where the count goes 1→0.
- **FWD**: drive `m_read`/`m_write` from the latch. When `m_waitrequest`=0 is sampled at an edge:
  - capture `m_readdata` into `s_readdata` (reads only; writes leave it unchanged);
  - deassert `m_read`/`m_write`;
  - go to RESP.
- **RESP**: one cycle with `s_waitrequest`=0, then always IDLE. A request held high is re-sampled in IDLE as a new transaction.
- Protocol check: in STALL or FWD, any change of `s_address`, `s_read`, `s_write`, `s_writedata` or `s_byteenable` relative to the latch sets `protocol_error`. The bridge ignores the change and completes the latched request.
- LFSR: 16-bit Galois, taps 16'hB400, shift right. It advances only on request acceptance.
- `stall_count` stops at 32'hFFFFFFFF (no wrap).

## Timing
- Reset values:
  - `s_waitrequest`=1;
  - `s_readdata`=0;
  - all `m_*` outputs 0;
  - `stall_count`=0;
  - `protocol_error`=0;
  - LFSR=seed.
- Asserting reset mid-transaction drops `m_read`/`m_write` immediately (asynchronous). The transaction is abandoned.
- Cycles from the first request cycle to completion = 1 (IDLE) + W (stall) + F (FWD cycles, ≥1) + 1 (RESP).
  - Minimum is 3, with W=0 and the RAM not stalling.
- `m_*` are asserted starting the cycle after IDLE+STALL. RAM-side latency adds directly to F.
- `s_readdata` is stable from RESP entry until the next read's FWD completion.

## Structure
- Package `mips_bus_pkg` holds:
  - the state enum `bridge_state_t`;
  - `LFSR_TAPS` = 16'hB400;
  - `BUS_DATA_W`=32 and `BUS_BE_W`=4.
- Sub-module `bus_lfsr16`: clk, reset, seed, step input and 16-bit state output. It is shared with future stall/fault injectors.

## Test plan
- `RANDOM`=0, `FIXED_WAIT`=2, RAM never stalls; CPU read of 0xBFC00028 holding 0xA17B0412 → `s_waitrequest` high for exactly 4 cycles, then low for 1 cycle with `s_readdata`=32'hA17B0412; `stall_count`=4.
- `RANDOM`=0, `FIXED_WAIT`=0; write 0xDEADBEEF to 0x100 with byteenable 4'b0011, then read back → `m_write` held 1 cycle; readback returns 0x0000BEEF (RAM pre-zeroed); 3-cycle latency each.
- `s_read` and `s_write` asserted together → `protocol_error`=1, `s_readdata`=0 after 2 cycles, `m_read`/`m_write` never asserted.
- `s_address` changed from 0x40 to 0x44 during STALL → `protocol_error`=1, `m_address`=0x40.
- Reset driven low while in FWD → `m_read`=0 and `s_waitrequest`=1 in the same cycle. After release, full `bgez` program run through the bridge with `RANDOM`=1 ends with v0=32'hA17B0412.
- `RANDOM`=1, seed 16'hACE1; 64 back-to-back reads → per-transaction stall counts match a reference LFSR model exactly.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus stall bridge and its helpers.
package mips_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = 4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StFwd,
    StResp
  } bridge_state_t;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/bus_lfsr16.sv
// 16-bit Galois LFSR that advances only when stepped; a zero seed is forced to 1.
module bus_lfsr16
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d, seed_eff;

  // An all-zero state would lock up the generator.
  assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
  assign state_d  = step ? lfsr_next(state_q) : state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= seed_eff;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mips_bus_stall_bridge.sv
// Avalon-style bridge that delays each CPU request by a fixed or LFSR-driven number of
// cycles before forwarding it to RAM; also counts stall cycles and flags master misbehaviour.
module mips_bus_stall_bridge
  import mips_bus_pkg::*;
#(
  parameter int unsigned WAIT_BITS  = 2,
  parameter bit          RANDOM     = 1'b1,
  parameter int unsigned FIXED_WAIT = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_ADDR_W-1:0] s_address,
  input  logic                  s_write,
  input  logic                  s_read,
  input  logic [BUS_DATA_W-1:0] s_writedata,
  input  logic [BUS_BE_W-1:0]   s_byteenable,
  output logic                  s_waitrequest,
  output logic [BUS_DATA_W-1:0] s_readdata,
  output logic [BUS_ADDR_W-1:0] m_address,
  output logic                  m_write,
  output logic                  m_read,
  output logic [BUS_DATA_W-1:0] m_writedata,
  output logic [BUS_BE_W-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [BUS_DATA_W-1:0] m_readdata,
  output logic [31:0]           stall_count,
  output logic                  protocol_error
);

  bridge_state_t state_q, state_d;

  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [BUS_BE_W-1:0]   be_q, be_d;
  logic                  wr_q, wr_d;
  logic [WAIT_BITS-1:0]  cnt_q, cnt_d;
  logic                  m_read_q, m_read_d;
  logic                  m_write_q, m_write_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
  logic                  perr_q, perr_d;
  logic [31:0]           stall_q, stall_d;

  logic [15:0]          lfsr_state;
  logic                 lfsr_step;
  logic [WAIT_BITS-1:0] wait_load;
  logic                 req_one, req_both, req_mismatch;

  bus_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign wait_load = RANDOM ? WAIT_BITS'(lfsr_state) : WAIT_BITS'(FIXED_WAIT);

  assign req_one  = s_read ^ s_write;
  assign req_both = s_read & s_write;

  // Anything the master changes while it is being stalled breaks the Avalon hold rule.
  assign req_mismatch = (s_address != addr_q) || (s_writedata != wdata_q) ||
                        (s_byteenable != be_q) || (s_write != wr_q) || (s_read != !wr_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    rdata_d   = rdata_q;
    perr_d    = perr_q;
    stall_d   = stall_q;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_both) begin
          perr_d  = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else if (req_one) begin
          addr_d    = s_address;
          wdata_d   = s_writedata;
          be_d      = s_byteenable;
          wr_d      = s_write;
          cnt_d     = wait_load;
          lfsr_step = 1'b1;
          if (wait_load != '0) begin
            state_d = StStall;
          end else begin
            state_d   = StFwd;
            m_read_d  = s_read;
            m_write_d = s_write;
          end
        end
      end
      StStall: begin
        cnt_d = cnt_q - WAIT_BITS'(1);
        if (cnt_q == WAIT_BITS'(1)) begin
          state_d   = StFwd;
          m_read_d  = !wr_q;
          m_write_d = wr_q;
        end
      end
      StFwd: begin
        if (!m_waitrequest) begin
          if (!wr_q) begin
            rdata_d = m_readdata;
          end
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (((state_q == StStall) || (state_q == StFwd)) && req_mismatch) begin
      perr_d = 1'b1;
    end

    if ((s_read || s_write) && s_waitrequest && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      rdata_q   <= '0;
      perr_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      rdata_q   <= rdata_d;
      perr_q    <= perr_d;
      stall_q   <= stall_d;
    end
  end

  assign s_waitrequest  = (state_q != StResp);
  assign s_readdata     = rdata_q;
  assign m_address      = addr_q;
  assign m_writedata    = wdata_q;
  assign m_byteenable   = be_q;
  assign m_read         = m_read_q;
  assign m_write        = m_write_q;
  assign stall_count    = stall_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_mips_bus_stall_bridge.sv
// Self-checking bench: random-latency bridge against a RAM model and a latency/LFSR reference,
// plus a fixed-wait instance for directed timing and protocol-hold checks.
module tb_mips_bus_stall_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Random-wait instance signals.
  logic [31:0] s_address, s_writedata, s_readdata, m_address, m_writedata, m_readdata;
  logic [3:0]  s_byteenable, m_byteenable;
  logic        s_read, s_write, s_waitrequest, m_read, m_write, m_waitrequest;
  logic [31:0] stall_count;
  logic        protocol_error;

  // Fixed-wait instance signals.
  logic [31:0] f_address, f_readdata, f_m_address, f_m_writedata, f_stall_count;
  logic [3:0]  f_m_byteenable;
  logic        f_read, f_waitrequest, f_m_read, f_m_write, f_protocol_error;

  mips_bus_stall_bridge #(
    .WAIT_BITS (2),
    .RANDOM    (1'b1),
    .FIXED_WAIT(1),
    .LFSR_SEED (16'hACE1)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_write       (s_write),
    .s_read        (s_read),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_read        (m_read),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .stall_count   (stall_count),
    .protocol_error(protocol_error)
  );

  mips_bus_stall_bridge #(
    .WAIT_BITS (2),
    .RANDOM    (1'b0),
    .FIXED_WAIT(2),
    .LFSR_SEED (16'hACE1)
  ) u_fix (
    .clk           (clk),
    .reset         (reset),
    .s_address     (f_address),
    .s_write       (1'b0),
    .s_read        (f_read),
    .s_writedata   (32'h0),
    .s_byteenable  (4'hF),
    .s_waitrequest (f_waitrequest),
    .s_readdata    (f_readdata),
    .m_address     (f_m_address),
    .m_write       (f_m_write),
    .m_read        (f_m_read),
    .m_writedata   (f_m_writedata),
    .m_byteenable  (f_m_byteenable),
    .m_waitrequest (1'b0),
    .m_readdata    (32'hA17B0412),
    .stall_count   (f_stall_count),
    .protocol_error(f_protocol_error)
  );

  // RAM slave: holds waitrequest for ram_k cycles of each request, then completes.
  logic [31:0] mem [256] = '{default: '0};
  int          ram_k = 0;
  int          ram_left = 0;

  assign m_waitrequest = (ram_left != 0);
  assign m_readdata    = mem[m_address[9:2]];

  always @(posedge clk) begin
    if (!(m_read || m_write)) begin
      ram_left <= ram_k;
    end else if (ram_left != 0) begin
      ram_left <= ram_left - 1;
    end else if (m_write) begin
      for (int b = 0; b < 4; b++) begin
        if (m_byteenable[b]) mem[m_address[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
      end
    end
  end

  // Reference state.
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [256];
  logic [15:0] ref_lfsr;
  int          exp_stalls;
  bit          at_resp;

  function automatic logic [15:0] ref_lfsr_adv(input logic [15:0] s);
    logic [15:0] shifted;
    shifted = {1'b0, s[15:1]};
    return s[0] ? (shifted ^ 16'hB400) : shifted;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the random instance; returns at the negedge of its response cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int k);
    int w, exp_cyc, cyc;
    ram_k        = k;
    s_read       = !wr;
    s_write      = wr;
    s_address    = addr;
    s_writedata  = wd;
    s_byteenable = be;
    w        = int'(ref_lfsr[1:0]);
    ref_lfsr = ref_lfsr_adv(ref_lfsr);
    exp_cyc  = 1 + w + (k + 1);
    if (at_resp) @(negedge clk);
    cyc = 0;
    while (s_waitrequest === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == w + 2) begin
        check("fwd_m_read", {31'b0, m_read}, {31'b0, !wr});
        check("fwd_m_write", {31'b0, m_write}, {31'b0, wr});
        check("fwd_m_address", m_address, addr);
        if (wr) check("fwd_m_writedata", m_writedata, wd);
      end
      @(negedge clk);
    end
    check(wr ? "write_latency" : "read_latency", cyc, exp_cyc);
    exp_stalls += exp_cyc;
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      check("read_data", s_readdata, ref_mem[addr[9:2]]);
    end
    at_resp = 1'b1;
  endtask

  task automatic drop_req();
    s_read  = 1'b0;
    s_write = 1'b0;
    @(negedge clk);
    at_resp = 1'b0;
  endtask

  initial begin
    int w, cyc;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    reset = 1'b0;
    s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0; s_byteenable = '0;
    f_read = 1'b0; f_address = '0;
    ref_lfsr = 16'hACE1; exp_stalls = 0; at_resp = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_waitrequest", {31'b0, s_waitrequest}, 32'd1);
    check("rst_readdata", s_readdata, 32'h0);
    check("rst_m_ctrl", {30'b0, m_read, m_write}, 32'h0);
    check("rst_m_address", m_address, 32'h0);
    check("rst_m_wdata_be", m_writedata ^ {28'h0, m_byteenable}, 32'h0);
    check("rst_stall_count", stall_count, 32'h0);
    check("rst_protocol_error", {31'b0, protocol_error}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Fixed two-cycle wait: 4 stalled cycles then one response cycle.
    f_read = 1'b1; f_address = 32'hBFC00028;
    cyc = 0;
    while (f_waitrequest === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 4) begin
        check("fix_m_read", {31'b0, f_m_read}, 32'd1);
        check("fix_m_write", {31'b0, f_m_write}, 32'd0);
        check("fix_m_be_wdata", {f_m_byteenable, f_m_writedata[27:0]}, 32'hF000_0000);
      end
      @(negedge clk);
    end
    check("fix_latency", cyc, 32'd4);
    check("fix_readdata", f_readdata, 32'hA17B0412);
    check("fix_stall_count", f_stall_count, 32'd4);
    f_read = 1'b0;
    @(negedge clk);

    // Address wobble during the stall must flag an error but forward the latched address.
    f_read = 1'b1; f_address = 32'h40;
    @(negedge clk);
    f_address = 32'h44;
    repeat (2) @(negedge clk);
    check("hold_m_read", {31'b0, f_m_read}, 32'd1);
    check("hold_m_address", f_m_address, 32'h40);
    check("hold_protocol_error", {31'b0, f_protocol_error}, 32'd1);
    @(negedge clk);
    check("hold_complete", {31'b0, f_waitrequest}, 32'd0);
    f_read = 1'b0; f_address = '0;
    @(negedge clk);

    // Directed partial write then readback.
    xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 0);
    drop_req();
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 0);
    check("beef_readback", s_readdata, 32'h0000BEEF);
    drop_req();

    // Random writes, then 64 back-to-back random reads.
    for (int i = 0; i < 16; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      xfer(1'b1, a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) drop_req();
    end
    if (at_resp) drop_req();
    for (int i = 0; i < 64; i++) begin
      a = (i % 4 == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
      xfer(1'b0, a, 32'h0, 4'hF, $urandom_range(0, 2));
    end
    drop_req();
    check("stall_count_total", stall_count, 32'(exp_stalls));
    check("no_protocol_error", {31'b0, protocol_error}, 32'd0);

    // Read and write together: error response with zero data, RAM untouched.
    s_read = 1'b1; s_write = 1'b1; s_address = 32'h100;
    check("both_idle_m", {30'b0, m_read, m_write}, 32'h0);
    @(negedge clk);
    check("both_resp", {31'b0, s_waitrequest}, 32'd0);
    check("both_readdata", s_readdata, 32'h0);
    check("both_protocol_error", {31'b0, protocol_error}, 32'd1);
    check("both_resp_m", {30'b0, m_read, m_write}, 32'h0);
    exp_stalls += 1;
    drop_req();
    check("both_stall_count", stall_count, 32'(exp_stalls));

    // Asynchronous reset during the forward phase.
    ram_k = 3;
    s_read = 1'b1; s_write = 1'b0; s_address = 32'h100;
    w = int'(ref_lfsr[1:0]);
    repeat (w + 1) @(negedge clk);
    check("pre_rst_m_read", {31'b0, m_read}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_m_read", {31'b0, m_read}, 32'd0);
    check("async_rst_waitrequest", {31'b0, s_waitrequest}, 32'd1);
    check("async_rst_perr", {31'b0, protocol_error}, 32'd0);
    check("async_rst_stall", stall_count, 32'h0);
    s_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ref_lfsr = 16'hACE1; exp_stalls = 0; at_resp = 1'b0;
    @(negedge clk);

    // LFSR restarts from the seed after reset.
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, $urandom_range(0, 1));
    end
    drop_req();
    check("post_rst_stall_count", stall_count, 32'(exp_stalls));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
